// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the EX/MEM pipeline stage (master) and the data memory controller (slave).
interface data_mem_ctrl_if;
  logic        MEM_READ_EN;
  logic        MEM_WRITE_EN;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        MEM_BUSYWAIT;
  logic        ACCESS_ERR;

  modport master (
    output MEM_READ_EN, MEM_WRITE_EN, FUNC3, ADDRESS, WRITE_DATA,
    input  READ_DATA, MEM_BUSYWAIT, ACCESS_ERR
  );

  modport slave (
    input  MEM_READ_EN, MEM_WRITE_EN, FUNC3, ADDRESS, WRITE_DATA,
    output READ_DATA, MEM_BUSYWAIT, ACCESS_ERR
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory with byte/halfword/word loads and stores, IDLE/BUSY/DONE handshake.
// Optional feature macro: DMEM_FAST_WRITE_EN (single-cycle stores that never stall the pipeline).
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input logic            CLK,
  input logic            RESET,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned AdrW = IdxW + 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

`ifdef DMEM_FAST_WRITE_EN
  localparam bit FastWrite = 1'b1;
`else
  localparam bit FastWrite = 1'b0;
`endif

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AdrW-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      func3_q, func3_d;
  logic            is_write_q, is_write_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            req;
  logic            fast_wr;
  logic [AdrW-1:0] acc_addr;
  logic [31:0]     acc_wdata;
  logic [2:0]      acc_func3;
  logic            acc_write;
  logic            acc_err;
  logic [IdxW-1:0] acc_idx;
  logic [31:0]     acc_word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_val;
  logic [31:0]     store_data;
  logic [3:0]      store_be;
  logic            mem_we;
  logic            busy;

  logic            unused_addr_hi;
  assign unused_addr_hi = ^bus.ADDRESS[31:AdrW];

  assign req     = bus.MEM_READ_EN | bus.MEM_WRITE_EN;
  assign fast_wr = FastWrite && (state_q == StIdle) && bus.MEM_WRITE_EN;

  // A fast store is performed straight from the bus; everything else from the latched request.
  assign acc_addr  = fast_wr ? bus.ADDRESS[AdrW-1:0] : addr_q;
  assign acc_wdata = fast_wr ? bus.WRITE_DATA : wdata_q;
  assign acc_func3 = fast_wr ? bus.FUNC3 : func3_q;
  assign acc_write = fast_wr | is_write_q;
  assign acc_idx   = acc_addr[AdrW-1:2];
  assign acc_word  = mem_q[acc_idx];

  always_comb begin
    acc_err = 1'b0;
    case (acc_func3)
      3'b000, 3'b100: acc_err = 1'b0;
      3'b001, 3'b101: acc_err = acc_addr[0];
      3'b010:         acc_err = (acc_addr[1:0] != 2'b00);
      default:        acc_err = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (acc_write && acc_func3[2]) begin
      acc_err = 1'b1;
    end
  end

  always_comb begin
    byte_sel = acc_word[{acc_addr[1:0], 3'b000} +: 8];
    half_sel = acc_addr[1] ? acc_word[31:16] : acc_word[15:0];
    case (acc_func3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = acc_word;
    endcase
  end

  always_comb begin
    case (acc_func3[1:0])
      2'b00: begin
        store_data = {4{acc_wdata[7:0]}};
        store_be   = 4'b0001 << acc_addr[1:0];
      end
      2'b01: begin
        store_data = {2{acc_wdata[15:0]}};
        store_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = acc_wdata;
        store_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    func3_d    = func3_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      StIdle: begin
        if (fast_wr) begin
          mem_we = ~acc_err;
          err_d  = acc_err;
        end else if (req) begin
          addr_d     = bus.ADDRESS[AdrW-1:0];
          wdata_d    = bus.WRITE_DATA;
          func3_d    = bus.FUNC3;
          is_write_d = bus.MEM_WRITE_EN;
          cnt_d      = CntInit;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          err_d   = acc_err;
          if (is_write_q) begin
            mem_we = ~acc_err;
          end else begin
            rdata_d = acc_err ? 32'h0 : load_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Request inputs still belong to the finished access here, so they are ignored.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (RESET) begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      StIdle:  busy = FastWrite ? (bus.MEM_READ_EN & ~bus.MEM_WRITE_EN) : req;
      StBusy:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
    if (RESET) begin
      busy = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    func3_q    <= func3_d;
    is_write_q <= is_write_d;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= store_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.READ_DATA    = rdata_q;
  assign bus.MEM_BUSYWAIT = busy;
  assign bus.ACCESS_ERR   = err_q & ~RESET;
endmodule
